fft_frame_collector: RTL and testbench
======================================

// Module: fft_frame_collector
// PURPOSE
//  Upstream feeder for FFT_Butterfly: accepts a real audio sample stream (valid/ready).
//  Assembles frames of buffer_size samples in two ping-pong banks.
//  Presents each full frame split into even-index and odd-index lanes on the packed buses FFT_Butterfly consumes.
//  A frame valid/ready handshake lets the FFT stage stall without losing samples.
// PARAMETERS
//  buffer_size  4   samples per frame; power of two, >= 4
//  sample_size  32  signed sample width in bits
//  count_size   16  width of frame_count
// PORTS
//  clk            in   1                            single clock, rising edge
//  rst_n          in   1                            asynchronous reset, active low
//  sample_in      in   sample_size                  signed real audio sample
//  sample_valid   in   1                            sample_in is valid this cycle
//  sample_ready   out  1                            collector can accept a sample
//  flush          in   1                            sync; discard the partially filled frame
//  even_fft_real  out  buffer_size*sample_size/2    lane i = frame sample 2i
//  even_fft_imag  out  buffer_size*sample_size/2    always 0 (real input)
//  odd_fft_real   out  buffer_size*sample_size/2    lane i = frame sample 2i+1
//  odd_fft_imag   out  buffer_size*sample_size/2    always 0
//  frame_valid    out  1                            a complete frame is presented
//  frame_ready    in   1                            downstream takes the frame
//  frame_count    out  count_size                   frames handed off; wraps modulo 2^count_size
// BEHAVIOUR
//  - Reset (async, rst_n=0) clears all storage, wr_idx=0, wr_bank=0, rd_bank=0, full[1:0]=0.
//    Outputs: sample_ready=1, frame_valid=0, frame_count=0, all data buses 0.
//  - Reset mid-frame drops both banks, including any frame that was not yet handed off.
//  - Accept = sample_valid && sample_ready, where sample_ready = !full[wr_bank] (combinational).
//  - On accept: store to bank[wr_bank][wr_idx], then wr_idx++.
//  - When wr_idx == buffer_size-1 on accept: set full[wr_bank], toggle wr_bank, wr_idx <= 0.
//  - frame_valid = full[rd_bank], registered state with no combinational path from inputs.
//  - Data buses are driven from bank[rd_bank].
//  - Handoff = frame_valid && frame_ready: clear full[rd_bank], toggle rd_bank, frame_count++.
//  - Latency: last sample accepted in cycle N -> frame_valid=1 in cycle N+1 (if that bank is next to read).
//  - Stall: while frame_valid && !frame_ready, the buses and frame_valid hold stable.
//  - Both banks full: sample_ready=0; no samples are accepted or lost.
//  - Simultaneous completion of bank X and handoff of bank Y in the same cycle: both take effect.
//  - Simultaneous handoff and sample accept on the same bank index are impossible,
//    because a full bank is never the write bank.
//  - flush: wr_idx <= 0 and the partial bank contents are ignored; full flags and rd side are untouched.
//  - flush together with an accept: flush wins, and the sample is discarded.
//  - flush together with an accept of the last sample: flush wins; the frame is not marked full.
//  - frame_count wraps from 2^count_size-1 to 0.
//  - Arithmetic: samples are stored verbatim, with no scaling. Imag buses are constant 0.
// CONFIGURATION
//  FFT_BITREV_EN defined:
//   - Within each half, lane i carries half-index bitrev(i, log2(buffer_size/2)).
//   - Example, buffer_size=8: even lanes carry samples 0,4,2,6 and odd lanes carry 1,5,3,7.
//   - This yields full decimation-in-time input order.
//  FFT_BITREV_EN undefined:
//   - Natural order: even lanes carry 0,2,4,6 and odd lanes carry 1,3,5,7.
//   - The permutation is purely wiring; timing and handshake are identical in both builds.
// STRUCTURE
//  - fft_pkg holds:
//    - the sample_t typedef (signed [sample_size-1:0]);
//    - localparam HALF = buffer_size/2 and IDX_W = $clog2(buffer_size);
//    - function bitrev(idx, width).
//  - Sub-module fft_frame_bank holds one bank: a write port (we, idx, data) and a packed
//    even/odd read-out. It is instantiated twice.
//  - Top level holds the pointer, full-flag and handshake logic plus the output mux.
// TESTING
//  - Reset: after reset -> sample_ready=1, frame_valid=0, frame_count=0, buses 0.
//  - Single frame, frame_ready=1: stream 10,20,30,40 (buffer_size=4)
//    -> frame_valid one cycle after 40 is accepted; even=[10,30], odd=[20,40]; frame_count=1.
//  - Back-pressure, frame_ready=0: stream 12 samples
//    -> 8 accepted, then sample_ready=0 and frame_valid=1 with a stable bus.
//    Release frame_ready -> frames 1..3 appear in order with no sample lost.
//  - Flush: send 1,2 then flush, then send 5,6,7,8 -> the frame is even=[5,7], odd=[6,8].
//  - Simultaneous events: complete bank 1 in the same cycle bank 0 is handed off
//    -> frame_valid stays 1, the bus switches to bank 1, frame_count increments by 1.
//  - FFT_BITREV_EN with buffer_size=8: stream 0..7 -> even lanes 0,4,2,6 and odd lanes 1,5,3,7.
//  - Wrap: with count_size=2, 5 handoffs -> frame_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT front end (frame collector and banks).
package fft_pkg;

  localparam int BUFFER_SIZE = 4;
  localparam int SAMPLE_SIZE = 32;
  localparam int COUNT_SIZE  = 16;
  localparam int HALF        = BUFFER_SIZE / 2;
  localparam int IDX_W       = $clog2(BUFFER_SIZE);

  typedef logic signed [SAMPLE_SIZE-1:0] sample_t;

  // Reverse the low 'width' bits of idx.
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned width);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < width; b++) begin
      r = (r << 1) | ((idx >> b) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame bank: single write port plus packed even/odd lane read-out.
// Lane order is natural by default; with FFT_BITREV_EN defined, lane i of each
// half carries half-index bitrev(i) so the FFT sees decimation-in-time order.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int buffer_size = BUFFER_SIZE,
  parameter int sample_size = SAMPLE_SIZE
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  we,
  input  logic [$clog2(buffer_size)-1:0]        idx,
  input  logic signed [sample_size-1:0]         data,
  output logic [buffer_size*sample_size/2-1:0]  even_real,
  output logic [buffer_size*sample_size/2-1:0]  odd_real
);

  localparam int half = buffer_size / 2;

  logic signed [sample_size-1:0] mem [buffer_size];

  // Sample storage; cleared on reset so the presented buses read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < buffer_size; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= data;
    end
  end

  for (genvar i = 0; i < half; i++) begin : g_lane
`ifdef FFT_BITREV_EN
    localparam int src = int'(bitrev(i, $clog2(half)));
`else
    localparam int src = i;
`endif
    assign even_real[i*sample_size +: sample_size] = mem[2*src];
    assign odd_real[i*sample_size +: sample_size]  = mem[2*src+1];
  end

endmodule

// File: rtl/fft_frame_collector.sv
// Ping-pong frame collector feeding FFT_Butterfly: packs a real sample stream
// into frames of buffer_size samples and hands them off on a valid/ready port.
// Build option: define FFT_BITREV_EN for bit-reversed lane order within each half.
module fft_frame_collector
  import fft_pkg::*;
#(
  parameter int buffer_size = BUFFER_SIZE,
  parameter int sample_size = SAMPLE_SIZE,
  parameter int count_size  = COUNT_SIZE
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic signed [sample_size-1:0]         sample_in,
  input  logic                                  sample_valid,
  output logic                                  sample_ready,
  input  logic                                  flush,
  output logic [buffer_size*sample_size/2-1:0]  even_fft_real,
  output logic [buffer_size*sample_size/2-1:0]  even_fft_imag,
  output logic [buffer_size*sample_size/2-1:0]  odd_fft_real,
  output logic [buffer_size*sample_size/2-1:0]  odd_fft_imag,
  output logic                                  frame_valid,
  input  logic                                  frame_ready,
  output logic [count_size-1:0]                 frame_count
);

  localparam int idx_w = $clog2(buffer_size);
  localparam int bus_w = buffer_size * sample_size / 2;

  logic [idx_w-1:0] wr_idx, wr_idx_nxt;
  logic             wr_bank, wr_bank_nxt;
  logic             rd_bank, rd_bank_nxt;
  logic [1:0]       full, full_nxt;
  logic [count_size-1:0] frame_count_nxt;

  logic             accept, store, last, handoff;
  logic [bus_w-1:0] even0, odd0, even1, odd1;

  assign sample_ready = !full[wr_bank];
  assign frame_valid  = full[rd_bank];
  assign accept       = sample_valid && sample_ready;
  // A flush in the same cycle discards the offered sample.
  assign store        = accept && !flush;
  assign last         = (wr_idx == idx_w'(buffer_size - 1));
  assign handoff      = frame_valid && frame_ready;

  // Next-state for write pointer, bank flags and handoff counter.
  always_comb begin
    wr_idx_nxt      = wr_idx;
    wr_bank_nxt     = wr_bank;
    rd_bank_nxt     = rd_bank;
    full_nxt        = full;
    frame_count_nxt = frame_count;
    if (handoff) begin
      full_nxt[rd_bank] = 1'b0;
      rd_bank_nxt       = !rd_bank;
      frame_count_nxt   = frame_count + 1'b1;
    end
    if (flush) begin
      wr_idx_nxt = '0;
    end else if (store) begin
      if (last) begin
        full_nxt[wr_bank] = 1'b1;
        wr_bank_nxt       = !wr_bank;
        wr_idx_nxt        = '0;
      end else begin
        wr_idx_nxt = wr_idx + 1'b1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx      <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      full        <= '0;
      frame_count <= '0;
    end else begin
      wr_idx      <= wr_idx_nxt;
      wr_bank     <= wr_bank_nxt;
      rd_bank     <= rd_bank_nxt;
      full        <= full_nxt;
      frame_count <= frame_count_nxt;
    end
  end

  fft_frame_bank #(.buffer_size(buffer_size), .sample_size(sample_size)) u_bank0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (store && !wr_bank),
    .idx       (wr_idx),
    .data      (sample_in),
    .even_real (even0),
    .odd_real  (odd0)
  );

  fft_frame_bank #(.buffer_size(buffer_size), .sample_size(sample_size)) u_bank1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (store && wr_bank),
    .idx       (wr_idx),
    .data      (sample_in),
    .even_real (even1),
    .odd_real  (odd1)
  );

  // Present the bank currently owned by the read side.
  always_comb begin
    even_fft_real = rd_bank ? even1 : even0;
    odd_fft_real  = rd_bank ? odd1  : odd0;
  end

  assign even_fft_imag = '0;
  assign odd_fft_imag  = '0;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Directed bench for fft_frame_collector (buffer_size=4) plus a count_size=2 instance for wrap.
module tb_fft_frame_collector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic signed [31:0] sample_in = '0;
  logic        sample_valid = 1'b0, sample_ready, flush = 1'b0;
  logic [63:0] even_fft_real, even_fft_imag, odd_fft_real, odd_fft_imag;
  logic        frame_valid, frame_ready = 1'b0;
  logic [15:0] frame_count;

  // wrap instance
  logic signed [31:0] w_sample_in = '0;
  logic        w_sample_valid = 1'b0, w_sample_ready, w_flush = 1'b0;
  logic [63:0] w_even_real, w_even_imag, w_odd_real, w_odd_imag;
  logic        w_frame_valid, w_frame_ready = 1'b1;
  logic [1:0]  w_frame_count;

  int tests = 0;
  int fails = 0;

  fft_frame_collector #(.buffer_size(4), .sample_size(32), .count_size(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .flush(flush),
    .even_fft_real(even_fft_real), .even_fft_imag(even_fft_imag),
    .odd_fft_real(odd_fft_real), .odd_fft_imag(odd_fft_imag),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_count(frame_count)
  );

  fft_frame_collector #(.buffer_size(4), .sample_size(32), .count_size(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .sample_in(w_sample_in), .sample_valid(w_sample_valid),
    .sample_ready(w_sample_ready), .flush(w_flush),
    .even_fft_real(w_even_real), .even_fft_imag(w_even_imag),
    .odd_fft_real(w_odd_real), .odd_fft_imag(w_odd_imag),
    .frame_valid(w_frame_valid), .frame_ready(w_frame_ready), .frame_count(w_frame_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // lane0 = a, lane1 = b
  function automatic logic [63:0] pk(input int a, input int b);
    return {32'(b), 32'(a)};
  endfunction

  // Offer one sample from a negedge; wait (bounded) for ready; accepted at the next posedge.
  task automatic push(input int v);
    int n;
    n = 0;
    @(negedge clk);
    sample_in = 32'(v);
    sample_valid = 1'b1;
    while (!sample_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) check("push_timeout", 64'(sample_ready), 64'd1);
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask

  // Hand off the presented frame in one cycle.
  task automatic take();
    @(negedge clk);
    frame_ready = 1'b1;
    @(posedge clk);
    #1 frame_ready = 1'b0;
  endtask

  initial begin
    int wrap_exp [5] = '{1, 2, 3, 0, 1};
    int k, sent;
    logic hv;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_sample_ready", 64'(sample_ready), 64'd1);
    check("rst_frame_valid", 64'(frame_valid), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_even_real", even_fft_real, 64'd0);
    check("rst_odd_real", odd_fft_real, 64'd0);
    check("rst_wrap_count", 64'(w_frame_count), 64'd0);

    // single frame with frame_ready=1
    frame_ready = 1'b1;
    push(10); push(20); push(30);
    check("single_not_yet_valid", 64'(frame_valid), 64'd0);
    push(40);
    check("single_valid_n1", 64'(frame_valid), 64'd1);
    check("single_even", even_fft_real, pk(10, 30));
    check("single_odd", odd_fft_real, pk(20, 40));
    check("single_imag", even_fft_imag | odd_fft_imag, 64'd0);
    check("single_count_before", 64'(frame_count), 64'd0);
    @(posedge clk); #1;
    check("single_count", 64'(frame_count), 64'd1);
    check("single_valid_after", 64'(frame_valid), 64'd0);
    frame_ready = 1'b0;

    // back-pressure: 8 fill both banks, the rest must wait
    for (int i = 0; i < 8; i++) push(101 + i);
    @(negedge clk);
    check("bp_sample_ready", 64'(sample_ready), 64'd0);
    check("bp_frame_valid", 64'(frame_valid), 64'd1);
    check("bp_even", even_fft_real, pk(101, 103));
    repeat (3) @(negedge clk);
    check("bp_hold_valid", 64'(frame_valid), 64'd1);
    check("bp_hold_even", even_fft_real, pk(101, 103));
    check("bp_hold_odd", odd_fft_real, pk(102, 104));
    take();
    @(negedge clk);
    check("bp_f2_even", even_fft_real, pk(105, 107));
    check("bp_f2_odd", odd_fft_real, pk(106, 108));
    check("bp_ready_again", 64'(sample_ready), 64'd1);
    for (int i = 0; i < 4; i++) push(109 + i);
    @(negedge clk);
    check("bp_full_again", 64'(sample_ready), 64'd0);
    check("bp_f2_still", odd_fft_real, pk(106, 108));
    take();
    @(negedge clk);
    check("bp_f3_even", even_fft_real, pk(109, 111));
    check("bp_f3_odd", odd_fft_real, pk(110, 112));
    take();
    @(negedge clk);
    check("bp_drained", 64'(frame_valid), 64'd0);
    check("bp_count", 64'(frame_count), 64'd4);

    // flush discards a partial frame
    push(1); push(2);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    push(5); push(6); push(7);
    check("flush_partial_not_valid", 64'(frame_valid), 64'd0);
    push(8);
    check("flush_valid", 64'(frame_valid), 64'd1);
    check("flush_even", even_fft_real, pk(5, 7));
    check("flush_odd", odd_fft_real, pk(6, 8));
    take();

    // flush together with the last sample: frame is not marked full
    push(-1); push(-2); push(-3);
    @(negedge clk);
    sample_in = -32'sd4; sample_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 sample_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_last_not_full", 64'(frame_valid), 64'd0);
    check("flush_last_count", 64'(frame_count), 64'd5);

    // completion of one bank in the same cycle the other is handed off
    push(21); push(22); push(23); push(24);
    push(31); push(-32); push(33);
    @(negedge clk);
    check("sim_pre_even", even_fft_real, pk(21, 23));
    sample_in = -32'sd34; sample_valid = 1'b1; frame_ready = 1'b1;
    @(posedge clk); #1 sample_valid = 1'b0; frame_ready = 1'b0;
    check("sim_valid", 64'(frame_valid), 64'd1);
    check("sim_even", even_fft_real, pk(31, 33));
    check("sim_odd", odd_fft_real, pk(-32, -34));
    check("sim_count", 64'(frame_count), 64'd6);
    take();
    @(negedge clk);
    check("sim_drained", 64'(frame_valid), 64'd0);
    check("sim_count_final", 64'(frame_count), 64'd7);

    // frame_count wrap on the count_size=2 instance
    k = 0;
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      w_sample_valid = (sent < 20);
      w_sample_in = 32'(sent);
      if (w_sample_valid && w_sample_ready) sent++;
      hv = w_frame_valid && w_frame_ready;
      @(posedge clk); #1;
      if (hv && k < 5) begin
        check($sformatf("wrap_count_%0d", k), 64'(w_frame_count), 64'(wrap_exp[k]));
        k++;
      end
    end
    w_sample_valid = 1'b0;
    check("wrap_handoffs", 64'(k), 64'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
